// File: rtl/edge_detect_fsm.sv
// edge_detect_fsm: Moore edge detector turning a slow level into a one-clock tick
// on each selected edge. An optional synchronizer sits ahead of the FSM.
// Optional feature: define EDGE_COUNT_EN to add the edge_count output and its
// wrapping tick counter.
module edge_detect_fsm #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             level,
    output logic             tick
`ifdef EDGE_COUNT_EN
    ,
    output logic [CNT_W-1:0] edge_count
`endif
);

    // Edge selection; any EDGE_MODE other than 1 or 2 behaves as rising-only.
    localparam logic RISE_EN = (EDGE_MODE != 32'd1);
    localparam logic FALL_EN = (EDGE_MODE == 32'd1) || (EDGE_MODE == 32'd2);

    typedef enum logic [3:0] {
        ZERO = 4'b0001,
        RISE = 4'b0010,
        ONE  = 4'b0100,
        FALL = 4'b1000
    } state_t;

    state_t state_q;
    logic   tick_q;
    logic   lv_c;

    // Reject illegal parameter values at elaboration.
    if (SYNC_STAGES > 3 || CNT_W == 0) begin : g_bad_param
        $error("edge_detect_fsm: SYNC_STAGES must be 0..3 and CNT_W nonzero");
    end

    // Optional synchronizer chain in front of the FSM.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign lv_c = level;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // Shift level through the synchronizer; cleared by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= level;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign lv_c = sync_q[SYNC_STAGES-1];
    end

    // Edge FSM; tick is registered alongside the state so it is a clean
    // decode of the state being entered (RISE and/or FALL).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ZERO;
            tick_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ZERO: begin
                    if (lv_c) begin
                        state_q <= RISE;
                        tick_q  <= RISE_EN;
                    end else begin
                        state_q <= ZERO;
                        tick_q  <= 1'b0;
                    end
                end
                RISE: begin
                    if (lv_c) begin
                        state_q <= ONE;
                        tick_q  <= 1'b0;
                    end else begin
                        state_q <= FALL;
                        tick_q  <= FALL_EN;
                    end
                end
                ONE: begin
                    if (lv_c) begin
                        state_q <= ONE;
                        tick_q  <= 1'b0;
                    end else begin
                        state_q <= FALL;
                        tick_q  <= FALL_EN;
                    end
                end
                FALL: begin
                    if (lv_c) begin
                        state_q <= RISE;
                        tick_q  <= RISE_EN;
                    end else begin
                        state_q <= ZERO;
                        tick_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ZERO;
                    tick_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tick = tick_q;

`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count ticks, wrapping naturally at 2^CNT_W; reset wins over an increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign edge_count = cnt_q;
`endif

endmodule

// File: tb/tb_edge_detect_fsm.sv
// Bench for edge_detect_fsm: four configurations share one stimulus table with
// hand-computed tick expectations, followed by a counter/reset sequence.
module tb_edge_detect_fsm;

    logic clk;
    logic rst;
    logic level;
    logic tick_a, tick_b, tick_c, tick_d;

    int unsigned total;
    int unsigned bad;

    // a: SYNC=0 rising, b: SYNC=2 falling, c: SYNC=0 both, d: SYNC=1 mode 3 (rising)
`ifdef EDGE_COUNT_EN
    logic [1:0] cnt_a, cnt_b, cnt_c, cnt_d;
    edge_detect_fsm #(.SYNC_STAGES(0), .EDGE_MODE(0), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .level(level), .tick(tick_a), .edge_count(cnt_a));
    edge_detect_fsm #(.SYNC_STAGES(2), .EDGE_MODE(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .level(level), .tick(tick_b), .edge_count(cnt_b));
    edge_detect_fsm #(.SYNC_STAGES(0), .EDGE_MODE(2), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .level(level), .tick(tick_c), .edge_count(cnt_c));
    edge_detect_fsm #(.SYNC_STAGES(1), .EDGE_MODE(3), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .level(level), .tick(tick_d), .edge_count(cnt_d));
`else
    edge_detect_fsm #(.SYNC_STAGES(0), .EDGE_MODE(0), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .level(level), .tick(tick_a));
    edge_detect_fsm #(.SYNC_STAGES(2), .EDGE_MODE(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .level(level), .tick(tick_b));
    edge_detect_fsm #(.SYNC_STAGES(0), .EDGE_MODE(2), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .level(level), .tick(tick_c));
    edge_detect_fsm #(.SYNC_STAGES(1), .EDGE_MODE(3), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .level(level), .tick(tick_d));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       level;
        logic [3:0] exp;   // {tick_a, tick_b, tick_c, tick_d} after the edge
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l);
        @(negedge clk);
        rst   = r;
        level = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        level = 1'b0;

        // Reset/level-held-high, 1,1,0,1 pattern, long high then low, 0-1-0 pulse.
        vecs[0]  = '{1'b1, 1'b1, 4'b0000};
        vecs[1]  = '{1'b0, 1'b1, 4'b1010};
        vecs[2]  = '{1'b1, 1'b1, 4'b0000};
        vecs[3]  = '{1'b1, 1'b0, 4'b0000};
        vecs[4]  = '{1'b0, 1'b1, 4'b1010};
        vecs[5]  = '{1'b0, 1'b1, 4'b0001};
        vecs[6]  = '{1'b0, 1'b0, 4'b0010};
        vecs[7]  = '{1'b0, 1'b1, 4'b1010};
        vecs[8]  = '{1'b0, 1'b1, 4'b0101};
        vecs[9]  = '{1'b0, 1'b1, 4'b0000};
        vecs[10] = '{1'b0, 1'b1, 4'b0000};
        vecs[11] = '{1'b0, 1'b0, 4'b0010};
        vecs[12] = '{1'b0, 1'b0, 4'b0000};
        vecs[13] = '{1'b0, 1'b0, 4'b0100};
        vecs[14] = '{1'b0, 1'b0, 4'b0000};
        vecs[15] = '{1'b0, 1'b1, 4'b1010};
        vecs[16] = '{1'b0, 1'b0, 4'b0011};
        vecs[17] = '{1'b0, 1'b0, 4'b0000};
        vecs[18] = '{1'b0, 1'b0, 4'b0100};
        vecs[19] = '{1'b0, 1'b0, 4'b0000};

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].level);
            check("tick_a", i, 32'(tick_a), 32'(vecs[i].exp[3]));
            check("tick_b", i, 32'(tick_b), 32'(vecs[i].exp[2]));
            check("tick_c", i, 32'(tick_c), 32'(vecs[i].exp[1]));
            check("tick_d", i, 32'(tick_d), 32'(vecs[i].exp[0]));
        end

        // Five rising edges on u_a with 2-bit counter, then reset mid-pulse.
        step(1'b1, 1'b0);
        check("seq_rst_tick", 100, 32'(tick_a), 32'd0);
`ifdef EDGE_COUNT_EN
        check("seq_rst_cnt", 100, 32'(cnt_a), 32'd0);
`endif
        for (int p = 0; p < 5; p++) begin
            step(1'b0, 1'b1);
            check("seq_hi_tick", 101 + 2 * p, 32'(tick_a), 32'd1);
`ifdef EDGE_COUNT_EN
            check("seq_hi_cnt", 101 + 2 * p, 32'(cnt_a), 32'(p % 4));
`endif
            step(1'b0, 1'b0);
            check("seq_lo_tick", 102 + 2 * p, 32'(tick_a), 32'd0);
`ifdef EDGE_COUNT_EN
            check("seq_lo_cnt", 102 + 2 * p, 32'(cnt_a), 32'((p + 1) % 4));
`endif
        end
        step(1'b0, 1'b1);
        check("mid_tick", 120, 32'(tick_a), 32'd1);
`ifdef EDGE_COUNT_EN
        check("mid_cnt", 120, 32'(cnt_a), 32'd1);
`endif
        step(1'b1, 1'b1);
        check("mid_rst_tick", 121, 32'(tick_a), 32'd0);
`ifdef EDGE_COUNT_EN
        check("mid_rst_cnt", 121, 32'(cnt_a), 32'd0);
`endif
        step(1'b0, 1'b1);
        check("post_rst_tick", 122, 32'(tick_a), 32'd1);
        check("post_rst_tick_c", 122, 32'(tick_c), 32'd1);
`ifdef EDGE_COUNT_EN
        check("post_rst_cnt", 122, 32'(cnt_a), 32'd0);
`endif
        step(1'b0, 1'b1);
        check("held_tick", 123, 32'(tick_a), 32'd0);
`ifdef EDGE_COUNT_EN
        check("held_cnt", 123, 32'(cnt_a), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
